// File: rtl/spi_reg_master_if.sv
// Host request/response and SPI pin bundle for spi_reg_master.
// The master modport is the initiator's view; the slave modport is the host/pin side.
interface spi_reg_master_if #(
    parameter int DSZ = 8
);
    logic           start;
    logic           we;
    logic [6:0]     addr;
    logic [DSZ-1:0] wr_data;
    logic           busy;
    logic           done;
    logic [DSZ-1:0] rd_data;
    logic           spi_clk;
    logic           spi_mosi;
    logic           spi_miso;
    logic           spi_ss;

    // Handshake: start is a request that is taken only in a cycle where busy=0
    // (we/addr/wr_data sampled with it); a start seen while busy=1 is dropped.
    // done pulses for one cycle when the frame ends, with rd_data updated on reads.
    modport master (
        input  start, we, addr, wr_data, spi_miso,
        output busy, done, rd_data, spi_clk, spi_mosi, spi_ss
    );
    modport slave (
        output start, we, addr, wr_data, spi_miso,
        input  busy, done, rd_data, spi_clk, spi_mosi, spi_ss
    );
endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator for the spi_slave register protocol: R/W bit, 7-bit address, DSZ data bits.
// Optional SPI_MASTER_CS_GAP_EN holds busy with spi_ss high for GAP_CYC cycles after each frame.
module spi_reg_master #(
    parameter int DSZ     = 8,
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    spi_reg_master_if.master bus,
    output logic [2:0]       state_dbg
);
    localparam int FRAME = 8 + DSZ;
    localparam int BW    = $clog2(FRAME);
    localparam logic [CLK_DIV-1:0] DIV_LAST = CLK_DIV'(CLK_DIV - 1);
    localparam logic [BW-1:0]      BIT_LAST = BW'(FRAME - 1);

    if (CLK_DIV < 1 || GAP_CYC < 1) begin : g_param_check
        $error("spi_reg_master: CLK_DIV and GAP_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CLK_DIV-1:0] div_q, div_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [FRAME-1:0]   tx_q, tx_d;
    logic [DSZ-1:0]     rx_q, rx_d;
    logic [DSZ-1:0]     rd_q, rd_d;
    logic               we_q, we_d;
    logic               sclk_q, sclk_d;
    logic               ss_q, ss_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SPI_MASTER_CS_GAP_EN
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    logic [GW-1:0]      gap_q, gap_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            sclk_q  <= 1'b0;
            ss_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SPI_MASTER_CS_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        we_d    = we_q;
        sclk_d  = sclk_q;
        ss_d    = ss_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start && !busy_q) begin
                    we_d    = bus.we;
                    tx_d    = {bus.we, bus.addr, (bus.we ? bus.wr_data : {DSZ{1'b0}})};
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + CLK_DIV'(1);
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + CLK_DIV'(1);
                end else if (!sclk_q) begin
                    div_d  = '0;
                    sclk_d = 1'b1;
                    rx_d   = DSZ'({rx_q, bus.spi_miso});
                end else begin
                    // Falling edge: the shift moves the next bit onto MOSI; after the
                    // last bit it leaves MOSI at 0 for the hold and idle time.
                    div_d  = '0;
                    sclk_d = 1'b0;
                    tx_d   = tx_q << 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            HOLD: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + CLK_DIV'(1);
                end else begin
                    div_d  = '0;
                    ss_d   = 1'b1;
                    done_d = 1'b1;
                    if (!we_q) begin
                        rd_d = rx_q;
                    end
`ifdef SPI_MASTER_CS_GAP_EN
                    gap_d   = '0;
                    state_d = GAP;
`else
                    busy_d  = 1'b0;
                    state_d = IDLE;
`endif
                end
            end
`ifdef SPI_MASTER_CS_GAP_EN
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.spi_clk  = sclk_q;
    assign bus.spi_mosi = tx_q[FRAME-1];
    assign bus.spi_ss   = ss_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_data  = rd_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: a CLK_DIV=2 instance checked every cycle against a frame-level
// model with a register slave, plus a CLK_DIV=1 instance for back-to-back framing.
module tb_spi_reg_master;
    localparam int DSZ     = 8;
    localparam int FRAME   = 8 + DSZ;
    localparam int GAP_CYC = 4;
    localparam int DIV_A   = 2;
`ifdef SPI_MASTER_CS_GAP_EN
    localparam int EXP_GAP = 1 + GAP_CYC;
    localparam bit GAP_ON  = 1'b1;
`else
    localparam int EXP_GAP = 1;
    localparam bit GAP_ON  = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    spi_reg_master_if #(.DSZ(DSZ)) a_if ();
    spi_reg_master_if #(.DSZ(DSZ)) b_if ();
    logic [2:0] a_state, b_state;

    spi_reg_master #(.DSZ(DSZ), .CLK_DIV(DIV_A), .GAP_CYC(GAP_CYC)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(a_if), .state_dbg(a_state)
    );
    spi_reg_master #(.DSZ(DSZ), .CLK_DIV(1), .GAP_CYC(GAP_CYC)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(b_if), .state_dbg(b_state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- register slave on instance A ----------------
    logic [DSZ-1:0] slave_data = '0;
    int s_cnt = 0;
    always @(negedge a_if.spi_ss) s_cnt = 0;
    always @(posedge a_if.spi_clk) s_cnt = s_cnt + 1;
    always_comb begin
        a_if.spi_miso = 1'b0;
        if (s_cnt >= 8 && s_cnt < FRAME) a_if.spi_miso = slave_data[DSZ-1-(s_cnt-8)];
    end

    // ---------------- scoreboard / compare process for A ----------------
    logic [0:0]       exp_q[$];
    logic [DSZ-1:0]   exp_rd_q[$];
    logic [DSZ-1:0]   model_rd = '0;
    logic [DSZ-1:0]   rd_now = '0;
    logic [FRAME-1:0] fw;
    logic [FRAME-1:0] mosi_word = '0;
    logic [FRAME-1:0] last_word = '0;
    logic             prev_sclk = 1'b0;
    int cyc = 0, acc_cyc = 0, rises = 0, dones = 0, last_lat = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            exp_rd_q.delete();
            model_rd  = '0;
            rd_now    = '0;
            rises     = 0;
            prev_sclk = 1'b0;
        end else begin
            if (a_if.spi_ss) check("sclk_idle_low", a_if.spi_clk, 1'b0);
            if (a_if.spi_clk && !prev_sclk) begin
                rises++;
                mosi_word = {mosi_word[FRAME-2:0], a_if.spi_mosi};
                check("ss_low_on_rise", a_if.spi_ss, 1'b0);
                if (exp_q.size() == 0) check("unexpected_rise", 1, 0);
                else check("mosi_bit", a_if.spi_mosi, exp_q.pop_front());
            end
            prev_sclk = a_if.spi_clk;
            if (a_if.done) begin
                dones++;
                last_lat  = cyc - acc_cyc;
                last_word = mosi_word;
                check("done_latency", cyc - acc_cyc, DIV_A * (2 * FRAME + 2) + 1);
                check("rises_per_frame", rises, FRAME);
                check("ss_at_done", a_if.spi_ss, 1'b1);
                check("busy_at_done", a_if.busy, GAP_ON);
                if (exp_rd_q.size() == 0) check("unexpected_done", 1, 0);
                else rd_now = exp_rd_q.pop_front();
            end
            check("rd_data", a_if.rd_data, rd_now);
            if (a_if.start && !a_if.busy) begin
                acc_cyc = cyc;
                rises   = 0;
                fw = {a_if.we, a_if.addr, (a_if.we ? a_if.wr_data : {DSZ{1'b0}})};
                for (int i = FRAME - 1; i >= 0; i--) exp_q.push_back(fw[i]);
                if (!a_if.we) model_rd = slave_data;
                exp_rd_q.push_back(model_rd);
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic a_send(input logic w, input logic [6:0] ad, input logic [DSZ-1:0] d);
        int k = 0;
        while (a_if.busy && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 500) check("a_busy_timeout", 1, 0);
        a_if.start = 1'b1; a_if.we = w; a_if.addr = ad; a_if.wr_data = d;
        @(posedge clk); #1;
        a_if.start = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget);
        int k = 0;
        while (dones < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_count", dones, target);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int r, gap, gap_busy, acc, lat, brises, bad, last_rise;
        logic pc, counting, gap_done;
        a_if.start = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wr_data = '0;
        b_if.start = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wr_data = '0;
        b_if.spi_miso = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss", a_if.spi_ss, 1'b1);
        check("rst_sclk", a_if.spi_clk, 1'b0);
        check("rst_mosi", a_if.spi_mosi, 1'b0);
        check("rst_busy", a_if.busy, 1'b0);
        check("rst_done", a_if.done, 1'b0);
        check("rst_rd", a_if.rd_data, '0);
        check("rst_b_ss", b_if.spi_ss, 1'b1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: write 0x5A to 0x7D
        a_send(1'b1, 7'h7D, 8'h5A);
        wait_dones(1, 200);
        check("t1_mosi_word", last_word, 16'hFD5A);
        check("t1_latency", last_lat, 69);
        check("t1_rd_unchanged", a_if.rd_data, 8'h00);

        // 2: read 0x7E, slave returns 0x03
        slave_data = 8'h03;
        a_send(1'b0, 7'h7E, 8'hFF);
        wait_dones(2, 200);
        check("t2_mosi_word", last_word, 16'h7E00);
        check("t2_rd", a_if.rd_data, 8'h03);

        // 3: a second start 10 cycles into a frame is dropped
        a_send(1'b1, 7'h12, 8'hC3);
        repeat (9) begin @(posedge clk); #1; end
        a_if.start = 1'b1; a_if.we = 1'b0; a_if.addr = 7'h55;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        wait_dones(3, 200);
        repeat (30) begin @(posedge clk); #1; end
        check("t3_single_done", dones, 3);
        check("t3_mosi_word", last_word, 16'h92C3);
        check("t3_rd_kept", a_if.rd_data, 8'h03);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: reset at the fifth SCLK rise, then a clean frame
        slave_data = 8'hA5;
        a_send(1'b0, 7'h33, 8'h00);
        r = 0; pc = 1'b0;
        for (int k = 0; k < 200 && r < 5; k++) begin
            if (a_if.spi_clk && !pc) r++;
            pc = a_if.spi_clk;
            if (r < 5) begin @(posedge clk); #1; end
        end
        check("t4_reached_rise5", r, 5);
        reset_n = 1'b0;
        #1;
        check("t4_ss", a_if.spi_ss, 1'b1);
        check("t4_sclk", a_if.spi_clk, 1'b0);
        check("t4_busy", a_if.busy, 1'b0);
        check("t4_done", a_if.done, 1'b0);
        check("t4_rd", a_if.rd_data, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check("t4_no_resume_ss", a_if.spi_ss, 1'b1);
        check("t4_no_resume_busy", a_if.busy, 1'b0);
        check("t4_no_resume_done", dones, 3);
        a_send(1'b0, 7'h7E, 8'h00);
        wait_dones(4, 200);
        check("t4_mosi_word", last_word, 16'h7E00);
        check("t4_rd", a_if.rd_data, 8'hA5);

        // 6: start held high on A, spi_ss gap between frames
        a_if.we = 1'b1; a_if.addr = 7'h01; a_if.wr_data = 8'h81; a_if.start = 1'b1;
        gap = 0; gap_busy = 0; counting = 1'b0; gap_done = 1'b0;
        for (int i = 0; i < 400 && !gap_done; i++) begin
            if (a_if.done) counting = 1'b1;
            if (counting) begin
                if (a_if.spi_ss) begin
                    gap++;
                    if (a_if.busy) gap_busy++;
                end else gap_done = 1'b1;
            end
            if (!gap_done) begin @(posedge clk); #1; end
        end
        a_if.start = 1'b0;
        check("t6_ss_gap", gap, EXP_GAP);
        check("t6_busy_in_gap", gap_busy, EXP_GAP - 1);
        wait_dones(6, 200);
        check("t6_mosi_word", last_word, 16'h8181);

        // 5: CLK_DIV=1 instance, start held high
        b_if.we = 1'b1; b_if.addr = 7'h7D; b_if.wr_data = 8'h5A; b_if.start = 1'b1;
        acc = -1; lat = -1; brises = 0; bad = 0; last_rise = -1; gap = 0; gap_busy = 0;
        pc = 1'b0; counting = 1'b0; gap_done = 1'b0;
        for (int i = 0; i < 300 && !gap_done; i++) begin
            if (acc < 0 && !b_if.busy) acc = i;
            if (acc >= 0 && lat < 0) begin
                if (b_if.spi_clk && !pc) begin
                    brises++;
                    if (last_rise >= 0 && i - last_rise != 2) bad++;
                    last_rise = i;
                end
                if (b_if.done) begin
                    lat = i - acc;
                    counting = 1'b1;
                end
            end
            if (counting) begin
                if (b_if.spi_ss) begin
                    gap++;
                    if (b_if.busy) gap_busy++;
                end else gap_done = 1'b1;
            end
            pc = b_if.spi_clk;
            if (!gap_done) begin @(posedge clk); #1; end
        end
        b_if.start = 1'b0;
        check("t5_latency", lat, 35);
        check("t5_rises", brises, 16);
        check("t5_sclk_period", bad, 0);
        check("t5_ss_gap", gap, EXP_GAP);
        check("t5_busy_in_gap", gap_busy, EXP_GAP - 1);
        repeat (80) begin @(posedge clk); #1; end
        check("t5_b_idle", b_if.busy, 1'b0);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_rd_queue_empty", exp_rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
